// File: rtl/i3c_pkg.sv
// ----------------------------------------------------------------------------
// i3c_pkg
// Shared definitions for the I3C ENTDAA sequencer:
//   - tx_mode_e   : frame-engine command encodings driven on o_tx_mode
//   - daa_state_e : sequencer FSM states
//   - BCAST_ADDR  : I3C broadcast address 7'h7E
//   - ENTDAA_CCC  : ENTDAA common command code
//   - RESERVED_LIST / is_reserved() : addresses never handed out dynamically
// ----------------------------------------------------------------------------
package i3c_pkg;

    typedef enum logic [2:0] {
        TX_START      = 3'd0,
        TX_SR         = 3'd1,
        TX_BYTE_W     = 3'd2,
        TX_BYTE_R_HDR = 3'd3,
        TX_STOP       = 3'd4
    } tx_mode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_HDR_W,
        ST_ACK_HDR,
        ST_CCC,
        ST_SR,
        ST_HDR_R,
        ST_ACK_R,
        ST_RD_ID,
        ST_ADDR,
        ST_ACK_A,
        ST_STOP,
        ST_DONE
    } daa_state_e;

    localparam logic [6:0] BCAST_ADDR = 7'h7E;
    localparam logic [7:0] ENTDAA_CCC = 8'h07;

    localparam int NUM_RESERVED = 8;
    localparam logic [NUM_RESERVED*7-1:0] RESERVED_LIST = {
        7'h3E, 7'h5E, 7'h6E, 7'h76, 7'h7A, 7'h7C, 7'h7E, 7'h7F
    };

    function automatic logic is_reserved(input logic [6:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_RESERVED; i++) begin
            if (RESERVED_LIST[i*7 +: 7] == addr) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/i3c_daa_addr_alloc.sv
// ----------------------------------------------------------------------------
// i3c_daa_addr_alloc
// Combinational next-legal-address generator for dynamic address assignment.
//   i_addr      : address just handed out
//   o_next_addr : i_addr + 1, stepping over reserved addresses
//   o_overflow  : the next legal address lies above 7'h77 (pool exhausted)
// ----------------------------------------------------------------------------
module i3c_daa_addr_alloc
    import i3c_pkg::*;
(
    input  logic [6:0] i_addr,
    output logic [6:0] o_next_addr,
    output logic       o_overflow
);

    // Eight bits so a wrap past 7'h7F shows up as overflow instead of
    // silently restarting at 0. At most two reserved addresses are
    // adjacent (7E, 7F), so two skip steps are enough.
    logic [7:0] cand0;
    logic [7:0] cand1;
    logic [7:0] cand2;

    always_comb begin
        cand0 = {1'b0, i_addr} + 8'd1;
        cand1 = cand0;
        if (!cand0[7] && is_reserved(cand0[6:0])) begin
            cand1 = cand0 + 8'd1;
        end
        cand2 = cand1;
        if (!cand1[7] && is_reserved(cand1[6:0])) begin
            cand2 = cand1 + 8'd1;
        end
        o_next_addr = cand2[6:0];
        o_overflow  = (cand2 > 8'h77);
    end

endmodule

// File: rtl/i3c_daa_sequencer.sv
// ----------------------------------------------------------------------------
// i3c_daa_sequencer
// Runs the I3C ENTDAA procedure on top of the SDR frame engine:
//   START, 7E/W, ENTDAA, { Sr, 7E/R, 64-bit PID/BCR/DCR, address, ACK }*, STOP
// and records every successfully addressed target in the register file.
//
// Ports
//   i_sdr_clk / i_sdr_rst_n : clock, asynchronous active-low reset
//   i_daa_en                : level run request; dropping it aborts the run
//   o_tx_en/o_tx_mode/o_tx_byte, i_tx_done : frame transmit handshake
//   o_rx_en, i_rx_done, i_rx_data           : 64-bit ID read handshake
//   o_ack_en, i_ack_valid, i_ack            : ACK-slot sample handshake
//   o_regf_*                                : register-file write port
//   o_num_assigned                          : targets assigned this run
//   o_done                                  : one-cycle end-of-run pulse
//   o_err                                   : sticky error, cleared at run start
// ----------------------------------------------------------------------------
module i3c_daa_sequencer
    import i3c_pkg::*;
#(
    parameter int         MAX_TARGETS = 8,
    parameter logic [6:0] BASE_ADDR   = 7'h08,
    parameter int         MAX_RETRY   = 2,
    parameter int         IDX_W       = 3
) (
    input  logic             i_sdr_clk,
    input  logic             i_sdr_rst_n,
    input  logic             i_daa_en,
    output logic             o_tx_en,
    output logic [2:0]       o_tx_mode,
    output logic [7:0]       o_tx_byte,
    input  logic             i_tx_done,
    output logic             o_rx_en,
    input  logic             i_rx_done,
    input  logic [63:0]      i_rx_data,
    output logic             o_ack_en,
    input  logic             i_ack_valid,
    input  logic             i_ack,
    output logic             o_regf_wr_en,
    output logic [IDX_W-1:0] o_regf_idx,
    output logic [63:0]      o_regf_id,
    output logic [6:0]       o_regf_dyn_addr,
    output logic [IDX_W:0]   o_num_assigned,
    output logic             o_done,
    output logic             o_err
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 2);
    localparam logic [IDX_W:0]     MAX_CNT   = MAX_TARGETS[IDX_W:0];
    localparam logic [RETRY_W-1:0] RETRY_LIM = MAX_RETRY[RETRY_W-1:0];

    daa_state_e         state_q,      state_d;
    logic               busy_q,       busy_d;
    logic               rearm_q,      rearm_d;
    logic               tx_en_q,      tx_en_d;
    tx_mode_e           tx_mode_q,    tx_mode_d;
    logic [7:0]         tx_byte_q,    tx_byte_d;
    logic               rx_en_q,      rx_en_d;
    logic               ack_en_q,     ack_en_d;
    logic [63:0]        id_q,         id_d;
    logic [6:0]         addr_q,       addr_d;
    logic [IDX_W:0]     count_q,      count_d;
    logic [RETRY_W-1:0] retry_q,      retry_d;
    logic               regf_wr_en_q, regf_wr_en_d;
    logic [IDX_W-1:0]   regf_idx_q,   regf_idx_d;
    logic [63:0]        regf_id_q,    regf_id_d;
    logic [6:0]         regf_addr_q,  regf_addr_d;
    logic               done_q,       done_d;
    logic               err_q,        err_d;

    logic               tx_evt;
    logic               rx_evt;
    logic               ack_evt;
    logic               abort;
    logic [IDX_W:0]     count_inc;
    logic [RETRY_W-1:0] retry_inc;
    logic [6:0]         next_addr;
    logic               next_ovf;

    i3c_daa_addr_alloc u_addr_alloc (
        .i_addr      (addr_q),
        .o_next_addr (next_addr),
        .o_overflow  (next_ovf)
    );

    // Completion pulses only count while the matching request is raised,
    // so a stray done/valid from the engine is ignored.
    assign tx_evt    = tx_en_q  & i_tx_done;
    assign rx_evt    = rx_en_q  & i_rx_done;
    assign ack_evt   = ack_en_q & i_ack_valid;
    assign abort     = ~i_daa_en;
    assign count_inc = count_q + 1'b1;
    assign retry_inc = retry_q + 1'b1;

    // Each working state has two phases: busy_q low raises the state's
    // request for one registered cycle, busy_q high waits for the matching
    // completion, drops the request and picks the next state. This leaves a
    // one-cycle gap with all requests low between consecutive frames.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        rearm_d      = rearm_q;
        tx_en_d      = tx_en_q;
        tx_mode_d    = tx_mode_q;
        tx_byte_d    = tx_byte_q;
        rx_en_d      = rx_en_q;
        ack_en_d     = ack_en_q;
        id_d         = id_q;
        addr_d       = addr_q;
        count_d      = count_q;
        retry_d      = retry_q;
        regf_wr_en_d = 1'b0;
        regf_idx_d   = regf_idx_q;
        regf_id_d    = regf_id_q;
        regf_addr_d  = regf_addr_q;
        done_d       = 1'b0;
        err_d        = err_q;

        if (state_q == ST_IDLE) begin
            // rearm_q blocks a restart until i_daa_en has been seen low.
            if (!i_daa_en) begin
                rearm_d = 1'b0;
            end
            if (i_daa_en && !rearm_q) begin
                err_d     = 1'b0;
                count_d   = '0;
                retry_d   = '0;
                tx_en_d   = 1'b1;
                tx_mode_d = TX_START;
                tx_byte_d = 8'h00;
                busy_d    = 1'b1;
                state_d   = ST_START;
            end
        end else if (state_q == ST_DONE) begin
            done_d  = 1'b1;
            rearm_d = 1'b1;
            state_d = ST_IDLE;
        end else if (!busy_q) begin
            busy_d = 1'b1;
            case (state_q)
                ST_START:  begin tx_en_d = 1'b1; tx_mode_d = TX_START;      tx_byte_d = 8'h00;              end
                ST_HDR_W:  begin tx_en_d = 1'b1; tx_mode_d = TX_BYTE_R_HDR; tx_byte_d = {BCAST_ADDR, 1'b0}; end
                ST_CCC:    begin tx_en_d = 1'b1; tx_mode_d = TX_BYTE_W;     tx_byte_d = ENTDAA_CCC;         end
                ST_SR:     begin tx_en_d = 1'b1; tx_mode_d = TX_SR;         tx_byte_d = 8'h00;              end
                ST_HDR_R:  begin tx_en_d = 1'b1; tx_mode_d = TX_BYTE_R_HDR; tx_byte_d = {BCAST_ADDR, 1'b1}; end
                // Address byte carries its own odd parity in bit 0, which
                // takes the place of the engine's T-bit.
                ST_ADDR:   begin tx_en_d = 1'b1; tx_mode_d = TX_BYTE_W;     tx_byte_d = {addr_q, ~^addr_q}; end
                ST_STOP:   begin tx_en_d = 1'b1; tx_mode_d = TX_STOP;       tx_byte_d = 8'h00;              end
                ST_ACK_HDR,
                ST_ACK_R,
                ST_ACK_A:  ack_en_d = 1'b1;
                ST_RD_ID:  rx_en_d  = 1'b1;
                default:   busy_d   = 1'b0;
            endcase
        end else begin
            case (state_q)
                ST_START: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_HDR_W;
                end
                ST_HDR_W: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_ACK_HDR;
                end
                ST_ACK_HDR: if (ack_evt) begin
                    ack_en_d = 1'b0; busy_d = 1'b0;
                    if (!i_ack) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = abort ? ST_STOP : ST_CCC;
                    end
                end
                ST_CCC: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_SR;
                end
                ST_SR: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_HDR_R;
                end
                ST_HDR_R: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_ACK_R;
                end
                // NACK on 7E/R simply means no unaddressed target is left.
                ST_ACK_R: if (ack_evt) begin
                    ack_en_d = 1'b0; busy_d = 1'b0;
                    state_d  = (!i_ack || abort) ? ST_STOP : ST_RD_ID;
                end
                ST_RD_ID: if (rx_evt) begin
                    rx_en_d = 1'b0; busy_d = 1'b0;
                    id_d    = i_rx_data;
                    state_d = abort ? ST_STOP : ST_ADDR;
                end
                ST_ADDR: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = abort ? ST_STOP : ST_ACK_A;
                end
                // An accepted address is always recorded, even when the run
                // is being aborted or the pool/slots are exhausted.
                ST_ACK_A: if (ack_evt) begin
                    ack_en_d = 1'b0; busy_d = 1'b0;
                    if (i_ack) begin
                        regf_wr_en_d = 1'b1;
                        regf_idx_d   = count_q[IDX_W-1:0];
                        regf_id_d    = id_q;
                        regf_addr_d  = addr_q;
                        count_d      = count_inc;
                        retry_d      = '0;
                        if (next_ovf) begin
                            err_d   = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            addr_d  = next_addr;
                            state_d = ((count_inc == MAX_CNT) || abort) ? ST_STOP : ST_SR;
                        end
                    end else begin
                        retry_d = retry_inc;
                        if (retry_inc > RETRY_LIM) begin
                            err_d   = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            state_d = abort ? ST_STOP : ST_SR;
                        end
                    end
                end
                ST_STOP: if (tx_evt) begin
                    tx_en_d = 1'b0; busy_d = 1'b0;
                    state_d = ST_DONE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, handshake requests and all registered outputs.
    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            rearm_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_mode_q    <= TX_START;
            tx_byte_q    <= 8'h00;
            rx_en_q      <= 1'b0;
            ack_en_q     <= 1'b0;
            id_q         <= '0;
            addr_q       <= BASE_ADDR;
            count_q      <= '0;
            retry_q      <= '0;
            regf_wr_en_q <= 1'b0;
            regf_idx_q   <= '0;
            regf_id_q    <= '0;
            regf_addr_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            rearm_q      <= rearm_d;
            tx_en_q      <= tx_en_d;
            tx_mode_q    <= tx_mode_d;
            tx_byte_q    <= tx_byte_d;
            rx_en_q      <= rx_en_d;
            ack_en_q     <= ack_en_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            retry_q      <= retry_d;
            regf_wr_en_q <= regf_wr_en_d;
            regf_idx_q   <= regf_idx_d;
            regf_id_q    <= regf_id_d;
            regf_addr_q  <= regf_addr_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_tx_en         = tx_en_q;
    assign o_tx_mode       = tx_mode_q;
    assign o_tx_byte       = tx_byte_q;
    assign o_rx_en         = rx_en_q;
    assign o_ack_en        = ack_en_q;
    assign o_regf_wr_en    = regf_wr_en_q;
    assign o_regf_idx      = regf_idx_q;
    assign o_regf_id       = regf_id_q;
    assign o_regf_dyn_addr = regf_addr_q;
    assign o_num_assigned  = count_q;
    assign o_done          = done_q;
    assign o_err           = err_q;

endmodule
